cricket_match_ctrl: RTL and testbench
=====================================

CRICKET_MATCH_CTRL -- requirements
Module: cricket_match_ctrl

Interface
REQ-001 SHALL have parameter BALLS_PER_INNINGS, default 120, meaning legal balls per innings (max 127).
REQ-002 SHALL have parameter MAX_WICKETS, default 10, meaning wickets ending an innings.
REQ-003 SHALL have parameter BREAK_CYCLES, default 4, meaning clock cycles spent in the innings break (>=1).
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  match start pulse, honoured only in IDLE or DONE.
REQ-007 SHALL have port ball_valid  input  1  a ball outcome is presented.
REQ-008 SHALL have port ball_ready  output  1  controller accepts a ball this cycle.
REQ-009 SHALL have port ball_runs  input  3  runs off the ball, 0..6 (7 treated as 6).
REQ-010 SHALL have port ball_wicket  input  1  batter out on this ball.
REQ-011 SHALL have port ball_extra  input  1  wide/no-ball flag (see Configuration).
REQ-012 SHALL have port team  output  1  batting team, 0 = first innings, 1 = second.
REQ-013 SHALL have ports runs  output  10; wickets  output  4; ball_count  output  7: current-innings totals.
REQ-014 SHALL have port target  output  10  first-innings runs + 1, valid from BREAK onward, 0 before.
REQ-015 SHALL have ports innings_over  output  1 (one-cycle pulse) and game_over  output  1 (level).
REQ-016 SHALL have port winner  output  2  00 none, 01 team 0, 10 team 1, 11 tie.

Function
REQ-017 SHALL implement states IDLE, INN1, BREAK, INN2, DONE.
REQ-018 SHALL assert ball_ready combinationally iff state is INN1 or INN2; a ball is accepted when ball_valid && ball_ready.
REQ-019 SHALL move IDLE/DONE -> INN1 on start, clearing runs, wickets, ball_count, target, winner, game_over, team.
REQ-020 SHALL register all totals; an accepted ball is reflected one cycle after acceptance.
REQ-021 SHALL, per accepted legal ball, add ball_runs to runs, increment ball_count, increment wickets if ball_wicket.
REQ-022 SHALL saturate runs at 1023 and never wrap.
REQ-023 SHALL end INN1 on the accepting edge when new ball_count == BALLS_PER_INNINGS or new wickets == MAX_WICKETS; next state BREAK.
REQ-024 SHALL end INN2 under the REQ-023 conditions or when new runs >= target (chase completed); next state DONE.
REQ-025 SHALL pulse innings_over for exactly one cycle, the first cycle in BREAK or DONE.
REQ-026 SHALL in BREAK latch target = INN1 runs + 1, hold INN1 totals for BREAK_CYCLES cycles, then clear totals, set team=1, enter INN2.
REQ-027 SHALL on entry to DONE set game_over=1 and winner: runs >= target -> 10; runs == target-1 -> 11; else 01.
REQ-028 SHALL hold all outputs stable in DONE until start or rst.
REQ-029 SHALL ignore start in INN1, BREAK, INN2, and ignore ball_valid when ball_ready is low.
REQ-030 SHALL, when the terminating ball also carries a wicket, count both runs and wicket before evaluating end conditions.

Reset
REQ-031 SHALL on rst return to IDLE with runs=0, wickets=0, ball_count=0, target=0, team=0, winner=00, game_over=0, innings_over=0, break counter=0.
REQ-032 SHALL let rst override start and ball acceptance in the same cycle, including mid-innings.

Configuration
REQ-033 SHALL compile extras handling only when CRICKET_EXTRAS_EN is defined.
REQ-034 SHALL, with CRICKET_EXTRAS_EN, treat an accepted ball with ball_extra=1 as adding ball_runs+1 runs, no ball_count increment, ball_wicket ignored; chase end (REQ-024) still applies.
REQ-035 SHALL, without CRICKET_EXTRAS_EN, ignore ball_extra and treat every accepted ball as legal.

Structure
REQ-036 SHALL place the state enum, winner encodings and default parameter constants in package cricket_pkg.
REQ-037 SHALL instantiate sub-module cricket_innings_counter (runs/wickets/balls accumulate, clear, saturation, end-condition flags) used by both innings.

Verification
REQ-038 Reset then start, 120 balls of 1 run -> INN1 ends with runs=120, ball_count=120, innings_over pulse 1 cycle, target=121 in BREAK.
REQ-039 INN1: 10 wicket balls of 0 runs -> BREAK after 10th ball, ball_count=10, wickets=10, target=1.
REQ-040 INN1 total 50; INN2 balls of 6 runs -> DONE after 9th ball (runs=54), winner=10, game_over=1, ball_ready=0.
REQ-041 INN1 total 30; INN2 120 balls totalling 30 -> winner=11; totalling 29 -> winner=01.
REQ-042 rst asserted mid-INN2 with ball_valid=1 -> next cycle IDLE, all outputs zero, ball not counted.
REQ-043 With CRICKET_EXTRAS_EN, extra with ball_runs=0, ball_wicket=1 -> runs +1, ball_count and wickets unchanged; without macro -> ball_count +1, wickets +1.

Source files
------------

// File: rtl/cricket_pkg.sv
// Shared types and constants for the cricket match controller.
// Optional extras handling is compiled in when CRICKET_EXTRAS_EN is defined.
package cricket_pkg;

    // Match controller states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INN1  = 3'd1,
        ST_BREAK = 3'd2,
        ST_INN2  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Winner encodings
    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_TEAM0 = 2'b01;
    localparam logic [1:0] WIN_TEAM1 = 2'b10;
    localparam logic [1:0] WIN_TIE   = 2'b11;

    // Default configuration constants
    localparam int DEF_BALLS_PER_INNINGS = 120;
    localparam int DEF_MAX_WICKETS       = 10;
    localparam int DEF_BREAK_CYCLES      = 4;

    // Largest representable run total
    localparam logic [9:0] RUNS_MAX = 10'd1023;

endpackage

// File: rtl/cricket_innings_counter.sv
// Per-innings accumulator: runs (saturating), wickets and legal balls, plus
// end-of-innings flags evaluated on the values the accepted ball produces.
// When CRICKET_EXTRAS_EN is defined, wides/no-balls add runs+1 and are not legal.
module cricket_innings_counter
    import cricket_pkg::*;
#(
    parameter int BALLS_PER_INNINGS = DEF_BALLS_PER_INNINGS,
    parameter int MAX_WICKETS       = DEF_MAX_WICKETS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       ball_acc,
    input  logic [2:0] ball_runs,
    input  logic       ball_wicket,
    input  logic       ball_extra,
    input  logic       chase_en,
    input  logic [9:0] target,
    output logic [9:0] runs,
    output logic [3:0] wickets,
    output logic [6:0] ball_count,
    output logic [9:0] runs_nxt,
    output logic       limit_hit,
    output logic       chase_hit
);

    logic [9:0]  runs_q, runs_d;
    logic [3:0]  wickets_q, wickets_d;
    logic [6:0]  balls_q, balls_d;
    logic [2:0]  runs_eff_s;
    logic [10:0] add_s;
    logic [10:0] sum_s;
    logic        legal_s;
    logic [3:0]  wk_nxt_s;
    logic [6:0]  balls_nxt_s;

`ifndef CRICKET_EXTRAS_EN
    logic unused_extra_s;
    assign unused_extra_s = ball_extra;
`endif

    // Next-value computation for an accepted ball and end-condition flags
    always_comb begin
        runs_eff_s = (ball_runs == 3'd7) ? 3'd6 : ball_runs;
        legal_s    = 1'b1;
        add_s      = {8'd0, runs_eff_s};
`ifdef CRICKET_EXTRAS_EN
        if (ball_extra) begin
            legal_s = 1'b0;
            add_s   = {8'd0, runs_eff_s} + 11'd1;
        end else begin
            legal_s = 1'b1;
        end
`endif
        sum_s    = {1'b0, runs_q} + add_s;
        runs_nxt = sum_s[10] ? RUNS_MAX : sum_s[9:0];

        wk_nxt_s = wickets_q;
        if (legal_s && ball_wicket && (wickets_q != 4'd15)) begin
            wk_nxt_s = wickets_q + 4'd1;
        end else begin
            wk_nxt_s = wickets_q;
        end

        balls_nxt_s = balls_q;
        if (legal_s && (balls_q != 7'd127)) begin
            balls_nxt_s = balls_q + 7'd1;
        end else begin
            balls_nxt_s = balls_q;
        end

        limit_hit = ball_acc && legal_s &&
                    ((balls_nxt_s == 7'(BALLS_PER_INNINGS)) ||
                     (wk_nxt_s == 4'(MAX_WICKETS)));
        chase_hit = ball_acc && chase_en && (runs_nxt >= target);

        runs_d    = runs_q;
        wickets_d = wickets_q;
        balls_d   = balls_q;
        if (clr) begin
            runs_d    = 10'd0;
            wickets_d = 4'd0;
            balls_d   = 7'd0;
        end else if (ball_acc) begin
            runs_d    = runs_nxt;
            wickets_d = wk_nxt_s;
            balls_d   = balls_nxt_s;
        end else begin
            runs_d    = runs_q;
            wickets_d = wickets_q;
            balls_d   = balls_q;
        end
    end

    // Total registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            runs_q    <= 10'd0;
            wickets_q <= 4'd0;
            balls_q   <= 7'd0;
        end else begin
            runs_q    <= runs_d;
            wickets_q <= wickets_d;
            balls_q   <= balls_d;
        end
    end

    assign runs       = runs_q;
    assign wickets    = wickets_q;
    assign ball_count = balls_q;

endmodule

// File: rtl/cricket_match_ctrl.sv
// Two-innings limited-overs match controller.
// Define CRICKET_EXTRAS_EN to enable wide/no-ball handling in the innings counter.
module cricket_match_ctrl
    import cricket_pkg::*;
#(
    parameter int BALLS_PER_INNINGS = DEF_BALLS_PER_INNINGS,
    parameter int MAX_WICKETS       = DEF_MAX_WICKETS,
    parameter int BREAK_CYCLES      = DEF_BREAK_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       ball_valid,
    output logic       ball_ready,
    input  logic [2:0] ball_runs,
    input  logic       ball_wicket,
    input  logic       ball_extra,
    output logic       team,
    output logic [9:0] runs,
    output logic [3:0] wickets,
    output logic [6:0] ball_count,
    output logic [9:0] target,
    output logic       innings_over,
    output logic       game_over,
    output logic [1:0] winner
);

    localparam int BRK_W = (BREAK_CYCLES > 1) ? $clog2(BREAK_CYCLES) : 1;
    localparam logic [BRK_W-1:0] BRK_LAST = BRK_W'(BREAK_CYCLES - 1);

    state_e           state_q, state_d;
    logic [BRK_W-1:0] brk_cnt_q, brk_cnt_d;
    logic [9:0]       target_q, target_d;
    logic             team_q, team_d;
    logic [1:0]       winner_q, winner_d;
    logic             game_over_q, game_over_d;
    logic             innings_over_q, innings_over_d;

    logic       ball_acc_s;
    logic       cnt_clr_s;
    logic       chase_en_s;
    logic [9:0] runs_nxt_s;
    logic       limit_hit_s;
    logic       chase_hit_s;

    assign ball_ready = (state_q == ST_INN1) || (state_q == ST_INN2);
    assign ball_acc_s = ball_valid && ball_ready;
    assign chase_en_s = (state_q == ST_INN2);

    cricket_innings_counter #(
        .BALLS_PER_INNINGS(BALLS_PER_INNINGS),
        .MAX_WICKETS      (MAX_WICKETS)
    ) u_counter (
        .clk        (clk),
        .rst        (rst),
        .clr        (cnt_clr_s),
        .ball_acc   (ball_acc_s),
        .ball_runs  (ball_runs),
        .ball_wicket(ball_wicket),
        .ball_extra (ball_extra),
        .chase_en   (chase_en_s),
        .target     (target_q),
        .runs       (runs),
        .wickets    (wickets),
        .ball_count (ball_count),
        .runs_nxt   (runs_nxt_s),
        .limit_hit  (limit_hit_s),
        .chase_hit  (chase_hit_s)
    );

    // Next-state and registered-output logic for the match sequence
    always_comb begin
        state_d        = state_q;
        brk_cnt_d      = brk_cnt_q;
        target_d       = target_q;
        team_d         = team_q;
        winner_d       = winner_q;
        game_over_d    = game_over_q;
        innings_over_d = 1'b0;
        cnt_clr_s      = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_INN1;
                    target_d    = 10'd0;
                    team_d      = 1'b0;
                    winner_d    = WIN_NONE;
                    game_over_d = 1'b0;
                    cnt_clr_s   = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            ST_INN1: begin
                if (limit_hit_s) begin
                    state_d        = ST_BREAK;
                    brk_cnt_d      = '0;
                    innings_over_d = 1'b1;
                    // Saturate so a maxed-out first innings cannot wrap the target
                    target_d       = (runs_nxt_s == RUNS_MAX) ? RUNS_MAX
                                                              : runs_nxt_s + 10'd1;
                end else begin
                    state_d = ST_INN1;
                end
            end
            ST_BREAK: begin
                if (brk_cnt_q == BRK_LAST) begin
                    state_d   = ST_INN2;
                    team_d    = 1'b1;
                    cnt_clr_s = 1'b1;
                    brk_cnt_d = '0;
                end else begin
                    brk_cnt_d = brk_cnt_q + BRK_W'(1);
                end
            end
            ST_INN2: begin
                if (limit_hit_s || chase_hit_s) begin
                    state_d        = ST_DONE;
                    innings_over_d = 1'b1;
                    game_over_d    = 1'b1;
                    if (runs_nxt_s >= target_q) begin
                        winner_d = WIN_TEAM1;
                    end else if (runs_nxt_s == (target_q - 10'd1)) begin
                        winner_d = WIN_TIE;
                    end else begin
                        winner_d = WIN_TEAM0;
                    end
                end else begin
                    state_d = ST_INN2;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Match-level registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            brk_cnt_q      <= '0;
            target_q       <= 10'd0;
            team_q         <= 1'b0;
            winner_q       <= WIN_NONE;
            game_over_q    <= 1'b0;
            innings_over_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            brk_cnt_q      <= brk_cnt_d;
            target_q       <= target_d;
            team_q         <= team_d;
            winner_q       <= winner_d;
            game_over_q    <= game_over_d;
            innings_over_q <= innings_over_d;
        end
    end

    assign team         = team_q;
    assign target       = target_q;
    assign winner       = winner_q;
    assign game_over    = game_over_q;
    assign innings_over = innings_over_q;

endmodule

// File: tb/tb_cricket_match_ctrl.sv
// Directed self-checking bench for cricket_match_ctrl (default parameters).
module tb_cricket_match_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       ball_valid;
    logic       ball_ready;
    logic [2:0] ball_runs;
    logic       ball_wicket;
    logic       ball_extra;
    logic       team;
    logic [9:0] runs;
    logic [3:0] wickets;
    logic [6:0] ball_count;
    logic [9:0] target;
    logic       innings_over;
    logic       game_over;
    logic [1:0] winner;

    int checks   = 0;
    int failures = 0;

    cricket_match_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .ball_valid  (ball_valid),
        .ball_ready  (ball_ready),
        .ball_runs   (ball_runs),
        .ball_wicket (ball_wicket),
        .ball_extra  (ball_extra),
        .team        (team),
        .runs        (runs),
        .wickets     (wickets),
        .ball_count  (ball_count),
        .target      (target),
        .innings_over(innings_over),
        .game_over   (game_over),
        .winner      (winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [2:0] r;
        logic       wk;
        logic       ex;
        logic       st;
        logic [9:0] e_runs;
        logic [3:0] e_wk;
        logic [6:0] e_balls;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bowl(input logic [2:0] r, input logic wk, input logic ex);
        ball_valid  = 1'b1;
        ball_runs   = r;
        ball_wicket = wk;
        ball_extra  = ex;
        tick();
        ball_valid  = 1'b0;
        ball_runs   = 3'd0;
        ball_wicket = 1'b0;
        ball_extra  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic start_match();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!ball_ready && n < 20) begin
            tick();
            n++;
        end
        check(name, 32'(ball_ready), 32'd1);
    endtask

    task automatic play(input int ones, input int total);
        for (int i = 0; i < total; i++) begin
            bowl((i < ones) ? 3'd1 : 3'd0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ball_valid = 1'b0;
        ball_runs = 3'd0; ball_wicket = 1'b0; ball_extra = 1'b0;

`ifdef CRICKET_EXTRAS_EN
        vecs[0] = '{1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 10'd4,  4'd0, 7'd1};
        vecs[1] = '{1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 10'd10, 4'd0, 7'd2};
        vecs[2] = '{1'b0, 3'd5, 1'b0, 1'b0, 1'b0, 10'd10, 4'd0, 7'd2};
        vecs[3] = '{1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 10'd12, 4'd1, 7'd3};
        vecs[4] = '{1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 10'd13, 4'd1, 7'd3};
        vecs[5] = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 10'd13, 4'd1, 7'd3};
        vecs[6] = '{1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 10'd13, 4'd1, 7'd4};
        vecs[7] = '{1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 10'd16, 4'd2, 7'd5};
`else
        vecs[0] = '{1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 10'd4,  4'd0, 7'd1};
        vecs[1] = '{1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 10'd10, 4'd0, 7'd2};
        vecs[2] = '{1'b0, 3'd5, 1'b0, 1'b0, 1'b0, 10'd10, 4'd0, 7'd2};
        vecs[3] = '{1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 10'd12, 4'd1, 7'd3};
        vecs[4] = '{1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 10'd12, 4'd2, 7'd4};
        vecs[5] = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 10'd12, 4'd2, 7'd4};
        vecs[6] = '{1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 10'd12, 4'd2, 7'd5};
        vecs[7] = '{1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 10'd15, 4'd3, 7'd6};
`endif

        // Reset state
        do_reset();
        check("rst_runs", 32'(runs), 32'd0);
        check("rst_wickets", 32'(wickets), 32'd0);
        check("rst_balls", 32'(ball_count), 32'd0);
        check("rst_target", 32'(target), 32'd0);
        check("rst_team", 32'(team), 32'd0);
        check("rst_winner", 32'(winner), 32'd0);
        check("rst_game_over", 32'(game_over), 32'd0);
        check("rst_innings_over", 32'(innings_over), 32'd0);
        check("rst_ready", 32'(ball_ready), 32'd0);

        // Table: single balls in the first innings
        start_match();
        check("start_ready", 32'(ball_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            ball_valid  = vecs[i].valid;
            ball_runs   = vecs[i].r;
            ball_wicket = vecs[i].wk;
            ball_extra  = vecs[i].ex;
            start       = vecs[i].st;
            tick();
            ball_valid = 1'b0; start = 1'b0; ball_extra = 1'b0; ball_wicket = 1'b0;
            check($sformatf("vec%0d_runs", i), 32'(runs), 32'(vecs[i].e_runs));
            check($sformatf("vec%0d_wickets", i), 32'(wickets), 32'(vecs[i].e_wk));
            check($sformatf("vec%0d_balls", i), 32'(ball_count), 32'(vecs[i].e_balls));
            check($sformatf("vec%0d_ready", i), 32'(ball_ready), 32'd1);
            check($sformatf("vec%0d_team", i), 32'(team), 32'd0);
        end

        // 120 singles end the first innings, then the break
        do_reset();
        start_match();
        play(119, 119);
        check("b119_innings_over", 32'(innings_over), 32'd0);
        check("b119_ready", 32'(ball_ready), 32'd1);
        bowl(3'd1, 1'b0, 1'b0);
        check("inn1_runs", 32'(runs), 32'd120);
        check("inn1_balls", 32'(ball_count), 32'd120);
        check("inn1_pulse", 32'(innings_over), 32'd1);
        check("inn1_target", 32'(target), 32'd121);
        check("brk_ready", 32'(ball_ready), 32'd0);
        ball_valid = 1'b1; ball_runs = 3'd4;
        tick();
        check("brk_pulse_off", 32'(innings_over), 32'd0);
        check("brk_hold_runs", 32'(runs), 32'd120);
        tick();
        ball_valid = 1'b0; ball_runs = 3'd0;
        tick();
        check("brk_still", 32'(ball_ready), 32'd0);
        check("brk_hold_runs2", 32'(runs), 32'd120);
        tick();
        check("inn2_ready", 32'(ball_ready), 32'd1);
        check("inn2_team", 32'(team), 32'd1);
        check("inn2_runs_clr", 32'(runs), 32'd0);
        check("inn2_balls_clr", 32'(ball_count), 32'd0);
        check("inn2_target", 32'(target), 32'd121);

        // Ten wickets end the first innings
        do_reset();
        start_match();
        repeat (9) bowl(3'd0, 1'b1, 1'b0);
        check("wk9_ready", 32'(ball_ready), 32'd1);
        bowl(3'd0, 1'b1, 1'b0);
        check("wk10_ready", 32'(ball_ready), 32'd0);
        check("wk10_wickets", 32'(wickets), 32'd10);
        check("wk10_balls", 32'(ball_count), 32'd10);
        check("wk10_target", 32'(target), 32'd1);
        check("wk10_pulse", 32'(innings_over), 32'd1);

        // Chase of 51 completed by sixes on the 9th ball
        do_reset();
        start_match();
        repeat (8) bowl(3'd6, 1'b0, 1'b0);
        bowl(3'd2, 1'b0, 1'b0);
        repeat (10) bowl(3'd0, 1'b1, 1'b0);
        check("chase_target", 32'(target), 32'd51);
        wait_ready("chase_wait");
        repeat (8) bowl(3'd6, 1'b0, 1'b0);
        check("chase_b8_ready", 32'(ball_ready), 32'd1);
        check("chase_b8_runs", 32'(runs), 32'd48);
        bowl(3'd6, 1'b0, 1'b0);
        check("chase_runs", 32'(runs), 32'd54);
        check("chase_winner", 32'(winner), 32'd2);
        check("chase_game_over", 32'(game_over), 32'd1);
        check("chase_ready", 32'(ball_ready), 32'd0);
        check("chase_pulse", 32'(innings_over), 32'd1);
        ball_valid = 1'b1; ball_runs = 3'd6;
        repeat (3) tick();
        ball_valid = 1'b0; ball_runs = 3'd0;
        check("done_hold_runs", 32'(runs), 32'd54);
        check("done_hold_winner", 32'(winner), 32'd2);
        check("done_hold_over", 32'(game_over), 32'd1);
        check("done_pulse_off", 32'(innings_over), 32'd0);

        // Restart from DONE: tie, then first-innings win
        start_match();
        check("restart_game_over", 32'(game_over), 32'd0);
        check("restart_winner", 32'(winner), 32'd0);
        check("restart_target", 32'(target), 32'd0);
        check("restart_team", 32'(team), 32'd0);
        check("restart_runs", 32'(runs), 32'd0);
        play(30, 120);
        check("tie_target", 32'(target), 32'd31);
        wait_ready("tie_wait");
        play(30, 120);
        check("tie_winner", 32'(winner), 32'd3);
        check("tie_game_over", 32'(game_over), 32'd1);
        start_match();
        play(30, 120);
        wait_ready("loss_wait");
        play(29, 120);
        check("loss_winner", 32'(winner), 32'd1);
        check("loss_balls", 32'(ball_count), 32'd120);
        check("loss_runs", 32'(runs), 32'd29);

        // Reset in the middle of the second innings with a ball presented
        do_reset();
        start_match();
        repeat (5) bowl(3'd6, 1'b0, 1'b0);
        repeat (10) bowl(3'd0, 1'b1, 1'b0);
        wait_ready("mid_wait");
        bowl(3'd2, 1'b0, 1'b0);
        bowl(3'd2, 1'b0, 1'b0);
        check("mid_runs", 32'(runs), 32'd4);
        rst = 1'b1; ball_valid = 1'b1; ball_runs = 3'd4; start = 1'b1;
        tick();
        rst = 1'b0; ball_valid = 1'b0; ball_runs = 3'd0; start = 1'b0;
        check("mrst_runs", 32'(runs), 32'd0);
        check("mrst_balls", 32'(ball_count), 32'd0);
        check("mrst_target", 32'(target), 32'd0);
        check("mrst_team", 32'(team), 32'd0);
        check("mrst_ready", 32'(ball_ready), 32'd0);
        tick();
        check("mrst_idle", 32'(ball_ready), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
